// File: rtl/rfile_wr_arb_pkg.sv
// Register-file writeback constants and writeback source encoding shared by
// the write-port arbiter and its round-robin sub-arbiter.
package rfile_wr_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 1 << ADDR_W;

  // Writeback source index, also the bit position in the valid/grant vectors
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/rfile_wr_arb_rr_arb2.sv
// Two-way round-robin arbiter: an uncontested requester always wins, a
// contested cycle goes to ptr and hands priority to the other source.
module rr_arb2
  import rfile_wr_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);

  always_comb begin
    grant    = valid;
    ptr_next = ptr;
    if (&valid) begin
      grant           = '0;
      grant[ptr]      = 1'b1;
      ptr_next        = ~ptr;
    end
  end

endmodule

// File: rtl/rfile_wr_arb.sv
// Shares the register-file write port between ALU and load writeback, drives
// a registered write port, and tracks outstanding writes per register.
module rfile_wr_arb
  import rfile_wr_arb_pkg::*;
#(
  parameter int DATA_W      = rfile_wr_arb_pkg::DATA_W,
  parameter int ADDR_W      = rfile_wr_arb_pkg::ADDR_W,
  parameter int NREG        = rfile_wr_arb_pkg::NREG,
  parameter bit HARDWIRE_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic [NREG-1:0]   busy,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data
);

  logic [1:0]        valid, grant;
  logic              rr_ptr, ptr_next;
  logic              accept, drop;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_next;

  assign valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .valid    (valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  assign req0_ready = grant[SRC_ALU] & ~rst;
  assign req1_ready = grant[SRC_MEM] & ~rst;
  assign accept     = |grant & ~rst;
  assign sel_reg    = grant[SRC_MEM] ? req1_reg  : req0_reg;
  assign sel_data   = grant[SRC_MEM] ? req1_data : req0_data;
  // r0 writes are handshaken normally but never reach the register file
  assign drop       = HARDWIRE_R0 && (sel_reg == '0);

  // Set beats clear so a newer in-flight writer keeps the register busy
  for (genvar r = 0; r < NREG; r++) begin : g_busy
    logic set, clr;
    assign set = issue_en && (issue_reg == ADDR_W'(r)) && !(HARDWIRE_R0 && r == 0);
    assign clr = write_en && (write_reg == ADDR_W'(r));
    assign busy_next[r] = set | (busy[r] & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      busy       <= '0;
      rr_ptr     <= 1'b0;
    end else begin
      write_en <= accept && !drop;
      if (accept && !drop) begin
        write_reg  <= sel_reg;
        write_data <= sel_data;
      end
      rr_ptr <= ptr_next;
      busy   <= busy_next;
    end
  end

endmodule
